// File: rtl/sp_fifo_pkg.sv
// Shared constants for the single-port-RAM FIFO: default widths and the
// depth / occupancy-count width derived from the RAM address width.
package sp_fifo_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 8;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Room for a full RAM plus the write buffer and the output register.
  function automatic int count_width(input int aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/sp_fifo_ctrl.sv
// FIFO controller driving a single-port RAM: one read or one write per cycle,
// with a one-word write buffer in front and a one-word output register behind.
module sp_fifo_ctrl
  import sp_fifo_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DW-1:0]               in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DW-1:0]               out_data,
  output logic [count_width(AW)-1:0]  count,
  output logic                        ram_ce,
  output logic                        ram_we,
  output logic [AW-1:0]               ram_addr,
  output logic [DW-1:0]               ram_wdata,
  input  logic [DW-1:0]               ram_rdata
);

  localparam int          DEPTH = depth_of(AW);
  localparam int          CW    = count_width(AW);
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic          wb_vld;
  logic [DW-1:0] wb_data;
  logic          rd_inflight;
  logic          ob_vld;
  logic [DW-1:0] ob_data;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;

  logic read_go;
  logic write_go;
  logic push;
  logic pop;

  // Reads win; a read is never followed by another read because of
  // rd_inflight, so a waiting write always gets the next slot.
  always_comb begin
    read_go  = (ram_cnt != '0) && !rd_inflight && (!ob_vld || out_ready);
    write_go = wb_vld && !read_go && (ram_cnt != FULL);
  end

  assign push = in_valid && !wb_vld;
  assign pop  = ob_vld && out_ready;

  assign ram_ce    = read_go || write_go;
  assign ram_we    = write_go;
  assign ram_addr  = write_go ? wptr : rptr;
  assign ram_wdata = wb_data;

  assign in_ready  = !wb_vld;
  assign out_valid = ob_vld;
  assign out_data  = ob_data;
  assign count     = CW'(ram_cnt) + CW'(wb_vld) + CW'(rd_inflight) + CW'(ob_vld);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      ram_cnt <= '0;
    end else begin
      if (write_go) begin
        wptr    <= wptr + 1'b1;
        ram_cnt <= ram_cnt + 1'b1;
      end else if (read_go) begin
        rptr    <= rptr + 1'b1;
        ram_cnt <= ram_cnt - 1'b1;
      end
    end
  end

  // A push can only land while the buffer is empty, so it never collides
  // with the buffer draining into the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld  <= 1'b0;
      wb_data <= '0;
    end else if (push) begin
      wb_vld  <= 1'b1;
      wb_data <= in_data;
    end else if (write_go) begin
      wb_vld  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      ob_vld      <= 1'b0;
      ob_data     <= '0;
    end else begin
      rd_inflight <= read_go;
      if (rd_inflight) begin
        ob_vld  <= 1'b1;
        ob_data <= ram_rdata;
      end else if (pop) begin
        ob_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sp_fifo_ctrl.sv
// Bench for sp_fifo_ctrl with AW=2 and a behavioural single-port RAM;
// a queue of pushed words is the reference for pop order and occupancy.
module tb_sp_fifo_ctrl;

  localparam int DW = 16;
  localparam int AW = 2;
  localparam int CW = AW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic          ram_ce;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sb [$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  sp_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one word until accepted; ok=0 if it never was.
  task automatic push_word(input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        sb.push_back(d);
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 || ram_ce !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_status: in_ready=%b out_valid=%b count=%0d ram_ce=%b, need 1 0 0 0",
               in_ready, out_valid, count, ram_ce);
    end
    n_checks++;
    if (out_data !== '0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_ram: out_data=%h we=%b addr=%0d wdata=%h, need all 0",
               out_data, ram_we, ram_addr, ram_wdata);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== '0 || ram_ce !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_release: in_ready=%b out_valid=%b count=%0d ram_ce=%b, need 1 0 0 0",
               in_ready, out_valid, count, ram_ce);
    end
  endtask

  task automatic test_single_word();
    logic [DW-1:0] exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_ready: in_ready=%b need 1", in_ready);
    end
    sb.push_back(in_data);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_addr !== '0 || ram_wdata !== 16'h1234 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL single_write: ce=%b we=%b addr=%0d wdata=%h count=%0d, need 1 1 0 1234 1",
               ram_ce, ram_we, ram_addr, ram_wdata, count);
    end
    tick();
    n_checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b0 || ram_addr !== '0 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL single_read: ce=%b we=%b addr=%0d count=%0d, need 1 0 0 1",
               ram_ce, ram_we, ram_addr, count);
    end
    tick();
    n_checks++;
    if (ram_ce !== 1'b0 || out_valid !== 1'b0 || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL single_inflight: ce=%b out_valid=%b count=%0d, need 0 0 1",
               ram_ce, out_valid, count);
    end
    tick();
    exp = sb.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== exp || count !== CW'(1)) begin
      n_fail++;
      $display("[TB] FAIL single_out: out_valid=%b out_data=%h count=%0d, need 1 %h 1",
               out_valid, out_data, count, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_pop: count=%0d out_valid=%b, need 0 0", count, out_valid);
    end
  endtask

  task automatic test_fill();
    bit ok;
    bit all_ok = 1'b1;
    int cyc = 0;
    logic [DW-1:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_word(DW'(i), ok);
      all_ok &= ok;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("[TB] FAIL fill_push_timeout: got %b need 1", all_ok);
    end
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (count !== CW'(6) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL fill_full: count=%0d in_ready=%b out_valid=%b, need 6 0 1",
               count, in_ready, out_valid);
    end
    out_ready = 1'b1;
    while (sb.size() > 0 && cyc < 80) begin
      #1;
      if (out_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL fill_order: out_data=%h need %h", out_data, exp);
        end
      end
      tick();
      n_checks++;
      if (count !== CW'(sb.size())) begin
        n_fail++;
        $display("[TB] FAIL fill_count: count=%0d need %0d", count, sb.size());
      end
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (sb.size() != 0 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL fill_drain: left=%0d count=%0d, need 0 0", sb.size(), count);
      sb.delete();
    end
  endtask

  task automatic test_arbitration();
    bit ok;
    bit all_ok = 1'b1;
    int cyc = 0;
    logic [DW-1:0] exp;
    out_ready = 1'b0;
    push_word(16'hA000, ok); all_ok &= ok;
    push_word(16'hB000, ok); all_ok &= ok;
    push_word(16'hC000, ok); all_ok &= ok;
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (!all_ok || count !== CW'(3) || ram_ce !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL arb_setup: pushed_ok=%b count=%0d ce=%b, need 1 3 0", all_ok, count, ram_ce);
    end
    in_valid = 1'b1;
    in_data  = 16'hD000;
    #1;
    if (in_ready) sb.push_back(in_data);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (ram_ce !== 1'b1 || ram_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL arb_read_first: ce=%b we=%b, need 1 0", ram_ce, ram_we);
    end
    while (sb.size() > 0 && cyc < 60) begin
      if (cyc == 1) begin
        n_checks++;
        if (ram_ce !== 1'b1 || ram_we !== 1'b1 || ram_wdata !== 16'hD000) begin
          n_fail++;
          $display("[TB] FAIL arb_write_next: ce=%b we=%b wdata=%h, need 1 1 d000",
                   ram_ce, ram_we, ram_wdata);
        end
      end
      if (out_valid) begin
        exp = sb.pop_front();
        n_checks++;
        if (out_data !== exp) begin
          n_fail++;
          $display("[TB] FAIL arb_order: out_data=%h need %h", out_data, exp);
        end
      end
      tick();
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (sb.size() != 0 || count !== '0) begin
      n_fail++;
      $display("[TB] FAIL arb_drain: left=%0d count=%0d, need 0 0", sb.size(), count);
      sb.delete();
    end
  endtask

  task automatic test_stream();
    int sent = 0, got = 0, cyc = 0, nwr = 0, nrd = 0;
    bit prev_rd = 1'b0;
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    while (got < 32 && cyc < 400) begin
      in_valid = (sent < 32);
      in_data  = DW'(sent) + 16'h0100;
      #1;
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("[TB] FAIL stream_spurious: out_data=%h with nothing outstanding", out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin
            n_fail++;
            $display("[TB] FAIL stream_order: out_data=%h need %h", out_data, exp);
          end
        end
        got++;
      end
      if (ram_ce && !ram_we) begin
        n_checks++;
        if (prev_rd) begin
          n_fail++;
          $display("[TB] FAIL stream_b2b_read: consecutive reads=1 need 0");
        end
        nrd++;
        prev_rd = 1'b1;
      end else begin
        prev_rd = 1'b0;
      end
      if (ram_ce && ram_we) nwr++;
      tick();
      n_checks++;
      if (count !== CW'(sb.size())) begin
        n_fail++;
        $display("[TB] FAIL stream_count: count=%0d need %0d", count, sb.size());
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (got != 32 || nwr != 32 || nrd != 32) begin
      n_fail++;
      $display("[TB] FAIL stream_totals: popped=%0d writes=%0d reads=%0d, need 32 32 32", got, nwr, nrd);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit all_ok = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word(16'hE000 + DW'(i), ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (!all_ok || count !== CW'(3)) begin
      n_fail++;
      $display("[TB] FAIL rstmid_setup: pushed_ok=%b count=%0d, need 1 3", all_ok, count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1 || ram_ce !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: count=%0d out_valid=%b in_ready=%b ce=%b, need 0 0 1 0",
               count, out_valid, in_ready, ram_ce);
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || count !== '0) begin
        n_fail++;
        $display("[TB] FAIL rstmid_idle: out_valid=%b count=%0d, need 0 0", out_valid, count);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_fill();
    test_arbitration();
    test_stream();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
